// File: rtl/operand_pkg.sv
// Shared select codes and default widths for the operand-select stage.
package operand_pkg;

  localparam int DW_DEF = 32;
  localparam int IW_DEF = 16;
  localparam int TW_DEF = 5;

  typedef enum logic [2:0] {
    SEL_PB    = 3'b000,
    SEL_HI    = 3'b001,
    SEL_LO    = 3'b010,
    SEL_PC    = 3'b011,
    SEL_SEXT  = 3'b100,
    SEL_LUI   = 3'b101,
    SEL_ZEXT  = 3'b110,
    SEL_SHAMT = 3'b111
  } sel_e;

endpackage

// File: rtl/opsel_skid_buffer.sv
// Two-entry skid buffer: head drives the output, spare absorbs one request during a stall.
// Latency 1 cycle into an empty buffer; in_ready is registered (spare empty), so stalls never drop data.
module opsel_skid_buffer #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         head_vld;
  logic         spare_vld;
  logic [W-1:0] head_dat;
  logic [W-1:0] spare_dat;
  logic         push;
  logic         pop;

  assign in_ready  = !spare_vld;
  assign out_valid = head_vld;
  assign out_data  = head_dat;
  assign push      = in_valid && in_ready;
  assign pop       = head_vld && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_vld  <= 1'b0;
      spare_vld <= 1'b0;
      head_dat  <= '0;
      spare_dat <= '0;
    end else if (flush) begin
      head_vld  <= 1'b0;
      spare_vld <= 1'b0;
    end else if (pop) begin
      // A full spare implies in_ready was low, so no push competes with the refill.
      if (spare_vld) begin
        head_dat  <= spare_dat;
        spare_vld <= 1'b0;
      end else begin
        head_vld <= push;
        if (push) head_dat <= in_data;
      end
    end else if (push) begin
      if (!head_vld) begin
        head_vld <= 1'b1;
        head_dat <= in_data;
      end else begin
        spare_vld <= 1'b1;
        spare_dat <= in_data;
      end
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// Registered second-operand select (PB/HI/LO/PC/immediate forms) feeding a 2-entry skid buffer.
// Latency 1 cycle; in_ready falls only when the spare entry fills. OPSEL_BYPASS_EN adds forwarding onto pb.
module operand_select_stage
  import operand_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    si,
  input  logic [DW-1:0] pb,
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] pc,
  input  logic [IW-1:0] imm,
  input  logic [TW-1:0] tag_in,
  input  logic          flush,
`ifdef OPSEL_BYPASS_EN
  input  logic          fwd_valid,
  input  logic [TW-1:0] fwd_tag,
  input  logic [DW-1:0] fwd_data,
  input  logic [TW-1:0] pb_tag,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] n,
  output logic [TW-1:0] tag_out
);

  logic [DW-1:0] pb_eff;
  logic [DW-1:0] opnd;

  always_comb begin
    pb_eff = pb;
`ifdef OPSEL_BYPASS_EN
    // $zero is hard-wired, so a forwarded write to tag 0 must never win.
    if (fwd_valid && (fwd_tag == pb_tag) && (pb_tag != '0)) pb_eff = fwd_data;
`endif
  end

  always_comb begin
    opnd = '0;
    case (sel_e'(si))
      SEL_PB:    opnd = pb_eff;
      SEL_HI:    opnd = hi;
      SEL_LO:    opnd = lo;
      SEL_PC:    opnd = pc;
      SEL_SEXT:  opnd = DW'($signed(imm));
      SEL_LUI:   opnd = DW'({imm, {DW{1'b0}}} >> IW);
      SEL_ZEXT:  opnd = DW'(imm);
      SEL_SHAMT: opnd = DW'(imm[10:6]);
      default:   opnd = '0;
    endcase
  end

  opsel_skid_buffer #(
    .W(DW + TW)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({tag_in, opnd}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({tag_out, n})
  );

endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage: queue-based reference model checked every cycle, plus literal expectations.
module tb_operand_select_stage;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    si;
  logic [DW-1:0] pb, hi, lo, pc;
  logic [IW-1:0] imm;
  logic [TW-1:0] tag_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] n;
  logic [TW-1:0] tag_out;
  logic          fwd_valid;
  logic [TW-1:0] fwd_tag;
  logic [DW-1:0] fwd_data;
  logic [TW-1:0] pb_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } ent_t;
  ent_t q[$];

  operand_select_stage #(.DW(DW), .IW(IW), .TW(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .si        (si),
    .pb        (pb),
    .hi        (hi),
    .lo        (lo),
    .pc        (pc),
    .imm       (imm),
    .tag_in    (tag_in),
    .flush     (flush),
`ifdef OPSEL_BYPASS_EN
    .fwd_valid (fwd_valid),
    .fwd_tag   (fwd_tag),
    .fwd_data  (fwd_data),
    .pb_tag    (pb_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand computed with plain integer arithmetic.
  function automatic logic [DW-1:0] model_op(input logic [2:0] s);
    longint v;
    logic [DW-1:0] b;
    b = pb;
`ifdef OPSEL_BYPASS_EN
    if (fwd_valid && fwd_tag == pb_tag && pb_tag != 0) b = fwd_data;
`endif
    v = longint'(imm);
    case (s)
      3'd0: return b;
      3'd1: return hi;
      3'd2: return lo;
      3'd3: return pc;
      3'd4: return DW'((v >= 32768) ? v - 65536 : v);
      3'd5: return DW'(v * 65536);
      3'd6: return DW'(v);
      default: return DW'((v / 64) % 32);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      bit acc;
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back('{d: model_op(si), t: tag_in});
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("n", 64'(n), 64'(q[0].d));
        chk("tag_out", 64'(tag_out), 64'(q[0].t));
      end
    end
  end

  task automatic offer(input logic [2:0] s, input logic [IW-1:0] im, input logic [TW-1:0] t);
    in_valid = 1'b1;
    si       = s;
    imm      = im;
    tag_in   = t;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; si = '0; imm = '0; tag_in = '0; flush = 1'b0;
    out_ready = 1'b0; pb = 32'h1111_1111; hi = 32'h2222_2222; lo = 32'h3333_3333;
    pc = 32'h0040_0000; fwd_valid = 1'b0; fwd_tag = '0; fwd_data = '0; pb_tag = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset n", 64'(n), 64'd0);
    chk("reset tag_out", 64'(tag_out), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    // Four back-to-back immediate forms, also a streaming throughput check.
    out_ready = 1'b1;
    offer(3'b100, 16'h8001, 5'd1); @(negedge clk);
    chk("sext", 64'(n), 64'hFFFF8001); chk("stream tag1", 64'(tag_out), 64'd1);
    offer(3'b110, 16'h8001, 5'd2); @(negedge clk);
    chk("zext", 64'(n), 64'h00008001); chk("stream tag2", 64'(tag_out), 64'd2);
    offer(3'b101, 16'h8001, 5'd3); @(negedge clk);
    chk("lui", 64'(n), 64'h80010000); chk("stream tag3", 64'(tag_out), 64'd3);
    offer(3'b111, 16'h07C0, 5'd4); @(negedge clk);
    chk("shamt", 64'(n), 64'h0000001F); chk("stream tag4", 64'(tag_out), 64'd4);
    chk("stream valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; @(negedge clk);
    chk("drained", 64'(out_valid), 64'd0);

    // Stall: A at head, B in spare, C held back until out_ready rises.
    out_ready = 1'b0;
    offer(3'b001, 16'h0, 5'd10); @(negedge clk);
    chk("stall A head", 64'(tag_out), 64'd10);
    offer(3'b010, 16'h0, 5'd11); @(negedge clk);
    chk("stall full in_ready", 64'(in_ready), 64'd0);
    offer(3'b011, 16'h0, 5'd12);
    repeat (3) begin
      @(negedge clk);
      chk("stall hold tag", 64'(tag_out), 64'd10);
      chk("stall hold n", 64'(n), 64'h2222_2222);
    end
    out_ready = 1'b1; @(negedge clk);
    chk("release B", 64'(tag_out), 64'd11);
    chk("release B n", 64'(n), 64'h3333_3333);
    @(negedge clk);
    chk("release C", 64'(tag_out), 64'd12);
    chk("release C n", 64'(n), 64'h0040_0000);
    in_valid = 1'b0; @(negedge clk);

    // Flush on a full buffer drops the contents and the concurrent request.
    out_ready = 1'b0;
    offer(3'b110, 16'h0005, 5'd20); @(negedge clk);
    offer(3'b110, 16'h0006, 5'd21); @(negedge clk);
    offer(3'b110, 16'h0007, 5'd22); flush = 1'b1; @(negedge clk);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; @(negedge clk);
    chk("flush dropped input", 64'(out_valid), 64'd0);

`ifdef OPSEL_BYPASS_EN
    out_ready = 1'b1;
    pb = 32'd5; pb_tag = 5'd3; fwd_valid = 1'b1; fwd_tag = 5'd3; fwd_data = 32'd9;
    offer(3'b000, 16'h0, 5'd7); @(negedge clk);
    chk("bypass hit", 64'(n), 64'd9);
    pb_tag = 5'd0; fwd_tag = 5'd0;
    offer(3'b000, 16'h0, 5'd8); @(negedge clk);
    chk("bypass zero tag", 64'(n), 64'd5);
    in_valid = 1'b0; fwd_valid = 1'b0; @(negedge clk);
`endif

    // Randomized traffic with occasional flush and one mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      si        = 3'($urandom_range(0, 7));
      imm       = IW'($urandom);
      tag_in    = TW'($urandom);
      pb        = $urandom; hi = $urandom; lo = $urandom; pc = $urandom;
      fwd_valid = $urandom_range(0, 1) != 0;
      fwd_tag   = TW'($urandom_range(0, 3));
      pb_tag    = TW'($urandom_range(0, 3));
      fwd_data  = $urandom;
      if (i == 1500) reset_n = 1'b0;
      if (i == 1502) reset_n = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
